// File: rtl/zion_riscv_isa_lib_pc_redirect.sv
// Fetch PC owner: sequential +4 fetch, EX branch/jump redirect with stall buffering and stale-request retire.
// Optional build macro ZION_RISCV_ISA_LIB_PC_REDIRECT_RVC_EN relaxes the target alignment check to 2 bytes.
module zion_riscv_isa_lib_pc_redirect #(
  parameter int unsigned RV64      = 0,
  parameter logic [63:0] RESET_PC  = 64'h8000_0000,
  localparam int unsigned CPU_WIDTH = 32 * (RV64 + 1)
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iExVld,
  input  logic [1:0]           iBjEn,
  input  logic [CPU_WIDTH-1:0] iTgtAddr,
  input  logic                 iFetchRdy,
  output logic                 oFetchVld,
  output logic [CPU_WIDTH-1:0] oFetchAddr,
  output logic                 oFlush,
  output logic                 oStaleAck,
  output logic                 oMisalign,
  output logic [CPU_WIDTH-1:0] oMisalignAddr
);

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t               state, state_d;
  logic [CPU_WIDTH-1:0] pc, pc_d;
  logic [CPU_WIDTH-1:0] pend, pend_d;
  logic [CPU_WIDTH-1:0] maddr, maddr_d;
  logic                 fetch_vld, fetch_vld_d;
  logic                 flush, flush_d;
  logic                 misalign, misalign_d;

  logic taken, misaligned, active, hs, redir, bad;

  // Target alignment: 2-byte granularity with compressed ISA, else 4-byte.
`ifdef ZION_RISCV_ISA_LIB_PC_REDIRECT_RVC_EN
  assign misaligned = iTgtAddr[0];
`else
  assign misaligned = |iTgtAddr[1:0];
`endif

  assign taken  = iExVld & (|iBjEn);
  assign active = (state != BOOT);
  assign hs     = fetch_vld & iFetchRdy;
  assign redir  = taken & ~misaligned & active;
  assign bad    = taken & misaligned & active;

  // Next-state and next-register logic.
  always_comb begin
    state_d     = state;
    pc_d        = pc;
    pend_d      = pend;
    maddr_d     = maddr;
    fetch_vld_d = fetch_vld;
    flush_d     = 1'b0;
    misalign_d  = 1'b0;
    case (state)
      BOOT: begin
        state_d     = RUN;
        fetch_vld_d = 1'b1;
      end
      RUN: begin
        if (hs) pc_d = pc + CPU_WIDTH'(4);
        if (redir) begin
          flush_d = 1'b1;
          if (hs || !fetch_vld) begin
            pc_d = iTgtAddr;
          end else begin
            // Outstanding request must keep its address; park the target.
            pend_d  = iTgtAddr;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (redir) begin
          flush_d = 1'b1;
          pend_d  = iTgtAddr;
        end
        if (hs) begin
          state_d = RUN;
          pc_d    = redir ? iTgtAddr : pend;
        end
      end
      default: begin
        state_d     = BOOT;
        fetch_vld_d = 1'b0;
      end
    endcase
    if (bad) begin
      misalign_d = 1'b1;
      maddr_d    = iTgtAddr;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state     <= BOOT;
      pc        <= CPU_WIDTH'(RESET_PC);
      pend      <= '0;
      maddr     <= '0;
      fetch_vld <= 1'b0;
      flush     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      pend      <= pend_d;
      maddr     <= maddr_d;
      fetch_vld <= fetch_vld_d;
      flush     <= flush_d;
      misalign  <= misalign_d;
    end
  end

  assign oFetchVld     = fetch_vld;
  assign oFetchAddr    = pc;
  assign oFlush        = flush;
  assign oMisalign     = misalign;
  assign oMisalignAddr = maddr;
  // Retire flag is tied to the handshake cycle of the pre-redirect request.
  assign oStaleAck     = (state == WAIT) & hs;

endmodule

// File: tb/tb_zion_riscv_isa_lib_pc_redirect.sv
// Directed bench for zion_riscv_isa_lib_pc_redirect: boot, redirect, stall buffering, misalign, wrap and mask.
module tb_zion_riscv_isa_lib_pc_redirect;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_vld, rdy;
  logic [1:0]  bj;
  logic [31:0] tgt;
  logic        vld, flush, stale, mis;
  logic [31:0] addr, maddr;

  logic        vld2, flush2, stale2, mis2;
  logic [31:0] addr2, maddr2;
  logic        ex_vld2 = 1'b0;
  logic [1:0]  bj2     = 2'b01;
  logic [31:0] tgt2    = 32'h1234_5678;
  logic        rdy2    = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  zion_riscv_isa_lib_pc_redirect dut (
    .iClk(clk), .iRst_n(rst_n), .iExVld(ex_vld), .iBjEn(bj), .iTgtAddr(tgt),
    .iFetchRdy(rdy), .oFetchVld(vld), .oFetchAddr(addr), .oFlush(flush),
    .oStaleAck(stale), .oMisalign(mis), .oMisalignAddr(maddr)
  );

  zion_riscv_isa_lib_pc_redirect #(.RV64(0), .RESET_PC(64'hFFFF_FFFC)) dut_wrap (
    .iClk(clk), .iRst_n(rst_n), .iExVld(ex_vld2), .iBjEn(bj2), .iTgtAddr(tgt2),
    .iFetchRdy(rdy2), .oFetchVld(vld2), .oFetchAddr(addr2), .oFlush(flush2),
    .oStaleAck(stale2), .oMisalign(mis2), .oMisalignAddr(maddr2)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic take(input logic [31:0] t, input logic [1:0] b);
    ex_vld = 1'b1;
    bj     = b;
    tgt    = t;
  endtask

  task automatic idle();
    ex_vld = 1'b0;
    bj     = 2'b00;
  endtask

  initial begin
    rst_n = 1'b0; ex_vld = 1'b0; bj = 2'b00; tgt = '0; rdy = 1'b1;
    #12;
    chk("rst_vld",   64'(vld),   64'd0);
    chk("rst_addr",  64'(addr),  64'h8000_0000);
    chk("rst_flush", 64'(flush), 64'd0);
    chk("rst_stale", 64'(stale), 64'd0);
    chk("rst_mis",   64'(mis),   64'd0);
    chk("rst_maddr", 64'(maddr), 64'd0);
    chk("rst_addr2", 64'(addr2), 64'hFFFF_FFFC);

    // T1 boot
    rst_n = 1'b1;
    #1;
    chk("t1_boot_vld", 64'(vld), 64'd0);
    tick();
    chk("t1_vld",   64'(vld),  64'd1);
    chk("t1_addr0", 64'(addr), 64'h8000_0000);
    chk("t6_addr0", 64'(addr2), 64'hFFFF_FFFC);
    tick();
    chk("t1_addr1", 64'(addr), 64'h8000_0004);
    chk("t6_wrap",  64'(addr2), 64'h0000_0000);
    chk("t6_noflush", 64'(flush2), 64'd0);
    tick();
    chk("t1_addr2", 64'(addr), 64'h8000_0008);
    chk("t6_addr2", 64'(addr2), 64'h0000_0004);

    // T2 redirect in RUN
    take(32'h8000_0100, 2'b10);
    tick();
    idle();
    chk("t2_addr",  64'(addr),  64'h8000_0100);
    chk("t2_flush", 64'(flush), 64'd1);
    chk("t2_stale", 64'(stale), 64'd0);
    tick();
    chk("t2_addr_next", 64'(addr),  64'h8000_0104);
    chk("t2_flush_off", 64'(flush), 64'd0);

    // T3 redirect under stall
    take(32'h8000_0010, 2'b01);
    tick();
    chk("t3_setup", 64'(addr), 64'h8000_0010);
    take(32'h8000_0200, 2'b10);
    rdy = 1'b0;
    tick();
    idle();
    chk("t3_hold0", 64'(addr),  64'h8000_0010);
    chk("t3_flush", 64'(flush), 64'd1);
    chk("t3_nostale", 64'(stale), 64'd0);
    tick();
    chk("t3_hold1", 64'(addr),  64'h8000_0010);
    chk("t3_flush_off", 64'(flush), 64'd0);
    tick();
    chk("t3_hold2", 64'(addr),  64'h8000_0010);
    rdy = 1'b1;
    #1;
    chk("t3_stale", 64'(stale), 64'd1);
    tick();
    chk("t3_addr",  64'(addr),  64'h8000_0200);
    chk("t3_stale_off", 64'(stale), 64'd0);

    // T4 double redirect in WAIT
    rdy = 1'b0;
    take(32'h8000_0200, 2'b01);
    tick();
    chk("t4_flush1", 64'(flush), 64'd1);
    take(32'h8000_0300, 2'b01);
    tick();
    idle();
    chk("t4_flush2", 64'(flush), 64'd1);
    chk("t4_hold",   64'(addr),  64'h8000_0200);
    tick();
    chk("t4_flush_off", 64'(flush), 64'd0);
    rdy = 1'b1;
    #1;
    chk("t4_stale", 64'(stale), 64'd1);
    tick();
    chk("t4_addr", 64'(addr), 64'h8000_0300);
    tick();
    chk("t4_addr_next", 64'(addr), 64'h8000_0304);

    // Taken in WAIT coincident with the handshake goes straight to pc
    rdy = 1'b0;
    take(32'h8000_0500, 2'b10);
    tick();
    rdy = 1'b1;
    take(32'h8000_0600, 2'b10);
    #1;
    chk("wait_hs_stale", 64'(stale), 64'd1);
    tick();
    idle();
    chk("wait_hs_addr",  64'(addr),  64'h8000_0600);
    chk("wait_hs_flush", 64'(flush), 64'd1);

    // T5 misaligned target
    take(32'h8000_0102, 2'b01);
    tick();
    idle();
`ifdef ZION_RISCV_ISA_LIB_PC_REDIRECT_RVC_EN
    chk("t5_addr",  64'(addr),  64'h8000_0102);
    chk("t5_flush", 64'(flush), 64'd1);
    chk("t5_mis",   64'(mis),   64'd0);
    tick();
    chk("t5_addr_next", 64'(addr), 64'h8000_0106);
    take(32'h8000_0105, 2'b01);
    tick();
    idle();
    chk("t5_odd_mis",   64'(mis),   64'd1);
    chk("t5_odd_maddr", 64'(maddr), 64'h8000_0105);
    chk("t5_odd_addr",  64'(addr),  64'h8000_010A);
    take(32'h8000_0600, 2'b01);
    tick();
    idle();
`else
    chk("t5_mis",   64'(mis),   64'd1);
    chk("t5_maddr", 64'(maddr), 64'h8000_0102);
    chk("t5_flush", 64'(flush), 64'd0);
    chk("t5_addr",  64'(addr),  64'h8000_0604);
    tick();
    chk("t5_mis_off",   64'(mis),   64'd0);
    chk("t5_maddr_hold", 64'(maddr), 64'h8000_0102);
    chk("t5_addr_next", 64'(addr),  64'h8000_0608);
`endif

    // Both taken bits set still counts as taken
    take(32'h8000_0700, 2'b11);
    tick();
    idle();
    chk("bj11_addr", 64'(addr), 64'h8000_0700);

    // iExVld low masks iBjEn
    ex_vld = 1'b0; bj = 2'b01; tgt = 32'h8000_0900;
    tick();
    chk("mask_addr",  64'(addr),  64'h8000_0704);
    chk("mask_flush", 64'(flush), 64'd0);
    idle();

    // Reset in WAIT drops the pending target
    rdy = 1'b0;
    take(32'h8000_0800, 2'b01);
    tick();
    idle();
    rst_n = 1'b0;
    #1;
    chk("wrst_vld",   64'(vld),   64'd0);
    chk("wrst_addr",  64'(addr),  64'h8000_0000);
    chk("wrst_flush", 64'(flush), 64'd0);
    #1;
    rst_n = 1'b1;
    rdy = 1'b1;
    tick();
    chk("wrst_boot_addr", 64'(addr), 64'h8000_0000);
    tick();
    chk("wrst_seq_addr",  64'(addr), 64'h8000_0004);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
